// File: rtl/div_nr_seq_ctrl_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Holds the controller state encoding used by div_nr_seq_ctrl.
package div_nr_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_SIGN = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/div_nr_seq_ctrl_step.sv
// div_nr_step: one combinational non-restoring division step.
// Ports: a/q/d in (partial remainder, quotient, divisor); a_nxt/q_nxt/add_sel out.
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             add_sel
);

    logic [WIDTH:0] a_sh;

    always_comb begin
        a_sh    = {a[WIDTH-1:0], q[WIDTH-1]};
        add_sel = a[WIDTH];
        // A negative partial remainder is repaired by adding on the next step.
        if (add_sel) a_nxt = a_sh + {1'b0, d};
        else         a_nxt = a_sh - {1'b0, d};
        q_nxt = {q[WIDTH-2:0], ~a_nxt[WIDTH]};
    end

endmodule

// File: rtl/div_nr_seq_ctrl.sv
// Sequential non-restoring divider: controller, operand registers, outputs.
// Ports: start/is_signed/dividend/divisor in; quotient/remainder/status out; result_ack in.
module div_nr_seq_ctrl
    import div_nr_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic             busy,
    output logic             first_cycle,
    output logic             add_sel,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             add_step;
    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .a       (a_q),
        .q       (q_q),
        .d       (d_q),
        .a_nxt   (a_step),
        .q_nxt   (q_step),
        .add_sel (add_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        q_d       = q_q;
        d_d       = d_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        accept    = start && (state_q == S_IDLE || state_q == S_DONE);
        dvd_neg   = is_signed & dividend[WIDTH-1];
        dvs_neg   = is_signed & divisor[WIDTH-1];

        unique case (state_q)
            S_IDLE: ;
            S_INIT: begin
                if (d_q == '0) begin
                    state_d = S_DONE;
                    quot_d  = '1;
                    // Q holds |dividend|; undo the magnitude to recover it raw.
                    rem_d   = neg_rem_q ? -q_q : q_q;
                    dz_d    = 1'b1;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (a_q[WIDTH]) a_d = a_q + {1'b0, d_q};
                state_d = S_SIGN;
            end
            S_SIGN: begin
                quot_d  = neg_quo_q ? -q_q : q_q;
                rem_d   = neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new request overrides a pending ack in DONE.
        if (accept) begin
            state_d   = S_INIT;
            cnt_d     = '0;
            a_d       = '0;
            q_d       = dvd_neg ? -dividend : dividend;
            d_d       = dvs_neg ? -divisor : divisor;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            quot_d    = '0;
            rem_d     = '0;
            dz_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            q_q       <= q_d;
            d_q       <= d_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy         = (state_q == S_INIT) || (state_q == S_ITER) ||
                          (state_q == S_FIX)  || (state_q == S_SIGN);
    assign first_cycle  = (state_q == S_INIT);
    assign add_sel      = (state_q == S_ITER) && add_step;
    assign result_valid = (state_q == S_DONE);
    assign quotient     = quot_q;
    assign remainder    = rem_q;
    assign div_by_zero  = dz_q;

endmodule
